toggle_decoder: RTL

TOGGLE_DECODER -- requirements
Module: toggle_decoder

---
 rtl/toggle_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/toggle_decoder.sv
// Toggle-encoded serial line decoder with sync hunt, bit destuffing and
// framing into FRAME_LEN-byte frames.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   line_in    - toggle-encoded line (level change = 1, no change = 0)
//   en         - bit strobe; line_in is sampled only when en=1
//   byte_out   - last assembled data byte (LSB received first)
//   byte_vld   - one-cycle pulse when byte_out is updated
//   in_frame   - high while the decoder is inside a frame
//   frame_done - one-cycle pulse with the last byte of a frame
//   err        - one-cycle pulse on a stuffing violation
module toggle_decoder #(
    parameter logic [7:0]  SYNC      = 8'h7E,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    input  logic       en,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       in_frame,
    output logic       frame_done,
    output logic       err
);

    localparam logic [7:0] LP_LEN = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HUNT,
        S_DATA
    } state_t;

    state_t     r_state;
    logic       r_prev;
    logic [7:0] r_hunt;
    logic [7:0] r_data;
    logic [7:0] r_bytecnt;
    logic [2:0] r_bitcnt;
    logic [2:0] r_ones;

    logic       w_dbit;
    logic [7:0] w_hunt_nxt;
    logic [7:0] w_data_nxt;
    logic [7:0] w_bytecnt_nxt;
    logic       w_stuff;
    logic       w_last;

    assign w_dbit        = line_in ^ r_prev;
    assign w_hunt_nxt    = {w_dbit, r_hunt[7:1]};
    assign w_data_nxt    = {w_dbit, r_data[7:1]};
    assign w_bytecnt_nxt = r_bytecnt + 8'd1;
    // Five ones in a row make the next bit a stuff bit.
    assign w_stuff       = (r_ones == 3'd5);
    assign w_last        = (w_bytecnt_nxt == LP_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_prev     <= 1'b0;
            r_hunt     <= 8'h00;
            r_data     <= 8'h00;
            r_bytecnt  <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_ones     <= 3'd0;
            byte_out   <= 8'h00;
            byte_vld   <= 1'b0;
            in_frame   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_vld   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // One settling step; no line sample is taken here.
                    r_state  <= S_HUNT;
                    in_frame <= 1'b0;
                end
                S_HUNT: begin
                    if (en) begin
                        r_prev <= line_in;
                        if (w_hunt_nxt == SYNC) begin
                            r_state   <= S_DATA;
                            in_frame  <= 1'b1;
                            r_hunt    <= 8'h00;
                            r_data    <= 8'h00;
                            r_bitcnt  <= 3'd0;
                            r_bytecnt <= 8'h00;
                            r_ones    <= 3'd0;
                        end else begin
                            r_hunt <= w_hunt_nxt;
                        end
                    end
                end
                S_DATA: begin
                    if (en) begin
                        r_prev <= line_in;
                        if (w_stuff) begin
                            if (w_dbit) begin
                                // Six ones: framing violation.
                                err      <= 1'b1;
                                r_state  <= S_HUNT;
                                in_frame <= 1'b0;
                                r_data   <= 8'h00;
                                r_bitcnt <= 3'd0;
                                r_ones   <= 3'd0;
                            end else begin
                                r_ones <= 3'd0;
                            end
                        end else begin
                            r_data <= w_data_nxt;
                            r_ones <= w_dbit ? r_ones + 3'd1 : 3'd0;
                            if (r_bitcnt == 3'd7) begin
                                byte_out  <= w_data_nxt;
                                byte_vld  <= 1'b1;
                                r_bitcnt  <= 3'd0;
                                r_bytecnt <= w_bytecnt_nxt;
                                if (w_last) begin
                                    frame_done <= 1'b1;
                                    r_state    <= S_HUNT;
                                    in_frame   <= 1'b0;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule
